// File: rtl/sample_fifo_if.sv
// Sample FIFO host-side bundle: decimator write strobe, reader handshake and status.
interface sample_fifo_if #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned AW     = 4
);
    logic [DATA_W-1:0] data_in;
    logic              new_data;
    logic              rd_en;
    logic              clr_overrun;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic [AW:0]       level;
    logic              wmark;
    logic              overrun;
    logic [7:0]        overrun_cnt;

    modport master (
        output data_in, new_data, rd_en, clr_overrun,
        input  rd_data, rd_valid, empty, full, level, wmark, overrun, overrun_cnt
    );

    modport slave (
        input  data_in, new_data, rd_en, clr_overrun,
        output rd_data, rd_valid, empty, full, level, wmark, overrun, overrun_cnt
    );
endinterface

// File: rtl/sample_fifo.sv
// Circular FIFO buffering decimated samples for a host reader, with level,
// watermark and sticky overrun accounting for samples dropped while full.
module sample_fifo #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AW     = 4,
    parameter int unsigned WMARK  = 8
) (
    input  logic        clk,
    input  logic        rst,
    sample_fifo_if.slave bus
);
    localparam int unsigned LW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     level;
    logic [LW-1:0]     level_nxt;
    logic              empty;
    logic              full;
    logic              wmark;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              overrun;
    logic [7:0]        overrun_cnt;

    logic rd_acc;
    logic wr_acc;
    logic drop;

    // A read in the same cycle frees a slot, so a write at full still lands.
    assign rd_acc = bus.rd_en && !empty;
    assign wr_acc = bus.new_data && (!full || rd_acc);
    assign drop   = bus.new_data && full && !rd_acc;

    always_comb begin
        level_nxt = level;
        if (wr_acc && !rd_acc) begin
            level_nxt = level + LW'(1);
        end else if (rd_acc && !wr_acc) begin
            level_nxt = level - LW'(1);
        end
    end

    // Storage is not reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            wmark       <= 1'b0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            overrun     <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            rd_valid <= rd_acc;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + AW'(1);
            end
            level <= level_nxt;
            empty <= (level_nxt == LW'(0));
            full  <= (level_nxt == LW'(DEPTH));
            wmark <= (level_nxt >= LW'(WMARK));
            // A drop coinciding with a clear counts as the first drop after it.
            if (drop) begin
                overrun <= 1'b1;
                if (bus.clr_overrun) begin
                    overrun_cnt <= 8'd1;
                end else if (overrun_cnt != 8'hFF) begin
                    overrun_cnt <= overrun_cnt + 8'd1;
                end
            end else if (bus.clr_overrun) begin
                overrun     <= 1'b0;
                overrun_cnt <= '0;
            end
        end
    end

    assign bus.rd_data     = rd_data;
    assign bus.rd_valid    = rd_valid;
    assign bus.empty       = empty;
    assign bus.full        = full;
    assign bus.level       = level;
    assign bus.wmark       = wmark;
    assign bus.overrun     = overrun;
    assign bus.overrun_cnt = overrun_cnt;
endmodule

// File: tb/tb_sample_fifo.sv
// Directed bench for sample_fifo: fill/drain, overrun, simultaneous access, wrap, reset.
module tb_sample_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    sample_fifo_if #(.DATA_W(12), .AW(4)) bus ();

    sample_fifo #(.DATA_W(12), .DEPTH(16), .AW(4), .WMARK(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic nd, input logic [11:0] d, input logic re, input logic clr);
        bus.new_data    = nd;
        bus.data_in     = d;
        bus.rd_en       = re;
        bus.clr_overrun = clr;
        @(posedge clk);
        #1;
        bus.new_data    = 1'b0;
        bus.rd_en       = 1'b0;
        bus.clr_overrun = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
        checks++; if (bus.level !== 5'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", bus.level); end
        checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", bus.full); end
        checks++; if (bus.wmark !== 1'b0) begin failures++; $display("FAIL reset_wmark got=%b exp=0", bus.wmark); end
        checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", bus.rd_valid); end
        checks++; if (bus.rd_data !== 12'h000) begin failures++; $display("FAIL reset_rd_data got=%h exp=000", bus.rd_data); end
        checks++; if (bus.overrun !== 1'b0 || bus.overrun_cnt !== 8'd0) begin
            failures++; $display("FAIL reset_overrun got=%b/%0d exp=0/0", bus.overrun, bus.overrun_cnt);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 12'(i), 1'b0, 1'b0);
            checks++; if (bus.level !== 5'(i)) begin failures++; $display("FAIL fill_level i=%0d got=%0d exp=%0d", i, bus.level, i); end
            checks++; if (bus.wmark !== (i >= 8)) begin failures++; $display("FAIL fill_wmark i=%0d got=%b exp=%b", i, bus.wmark, (i >= 8)); end
            checks++; if (bus.full !== (i == 16)) begin failures++; $display("FAIL fill_full i=%0d got=%b exp=%b", i, bus.full, (i == 16)); end
        end
        for (int i = 1; i <= 16; i++) begin
            drive(1'b0, 12'h000, 1'b1, 1'b0);
            checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 12'(i)) begin
                failures++; $display("FAIL drain_data i=%0d got=%b/%h exp=1/%h", i, bus.rd_valid, bus.rd_data, 12'(i));
            end
            checks++; if (bus.wmark !== ((16 - i) >= 8)) begin failures++; $display("FAIL drain_wmark i=%0d got=%b", i, bus.wmark); end
        end
        checks++; if (bus.empty !== 1'b1 || bus.level !== 5'd0) begin
            failures++; $display("FAIL drain_empty got=%b/%0d exp=1/0", bus.empty, bus.level);
        end
        drive(1'b0, 12'h000, 1'b0, 1'b0);
        checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL drain_pulse got=%b exp=0", bus.rd_valid); end
        checks++; if (bus.rd_data !== 12'h010) begin failures++; $display("FAIL drain_hold got=%h exp=010", bus.rd_data); end
    endtask

    task automatic test_overrun();
        logic [11:0] drops [3];
        drops = '{12'hAAA, 12'hBBB, 12'hCCC};
        for (int i = 1; i <= 16; i++) drive(1'b1, 12'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, drops[i], 1'b0, 1'b0);
        checks++; if (bus.level !== 5'd16 || bus.full !== 1'b1) begin failures++; $display("FAIL ovr_level got=%0d exp=16", bus.level); end
        checks++; if (bus.overrun !== 1'b1 || bus.overrun_cnt !== 8'd3) begin
            failures++; $display("FAIL ovr_count got=%b/%0d exp=1/3", bus.overrun, bus.overrun_cnt);
        end
        for (int i = 1; i <= 16; i++) begin
            drive(1'b0, 12'h000, 1'b1, 1'b0);
            checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 12'(i)) begin
                failures++; $display("FAIL ovr_data i=%0d got=%b/%h exp=1/%h", i, bus.rd_valid, bus.rd_data, 12'(i));
            end
        end
        drive(1'b0, 12'h000, 1'b1, 1'b0);
        checks++; if (bus.rd_valid !== 1'b0 || bus.empty !== 1'b1) begin
            failures++; $display("FAIL ovr_empty_read got=%b/%b exp=0/1", bus.rd_valid, bus.empty);
        end
        drive(1'b0, 12'h000, 1'b0, 1'b1);
        checks++; if (bus.overrun !== 1'b0 || bus.overrun_cnt !== 8'd0) begin
            failures++; $display("FAIL ovr_clear got=%b/%0d exp=0/0", bus.overrun, bus.overrun_cnt);
        end
    endtask

    task automatic test_simul_full();
        for (int i = 1; i <= 16; i++) drive(1'b1, 12'(i), 1'b0, 1'b0);
        drive(1'b1, 12'h7FF, 1'b1, 1'b0);
        checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 12'h001) begin
            failures++; $display("FAIL simul_data got=%b/%h exp=1/001", bus.rd_valid, bus.rd_data);
        end
        checks++; if (bus.level !== 5'd16 || bus.full !== 1'b1) begin failures++; $display("FAIL simul_level got=%0d exp=16", bus.level); end
        checks++; if (bus.overrun !== 1'b0 || bus.overrun_cnt !== 8'd0) begin
            failures++; $display("FAIL simul_overrun got=%b/%0d exp=0/0", bus.overrun, bus.overrun_cnt);
        end
        for (int i = 2; i <= 17; i++) begin
            drive(1'b0, 12'h000, 1'b1, 1'b0);
            checks++; if (bus.rd_data !== ((i == 17) ? 12'h7FF : 12'(i))) begin
                failures++; $display("FAIL simul_order i=%0d got=%h", i, bus.rd_data);
            end
        end
        checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL simul_empty got=%b exp=1", bus.empty); end
    endtask

    task automatic test_empty_rw();
        drive(1'b1, 12'h123, 1'b1, 1'b0);
        checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL empty_rw_valid got=%b exp=0", bus.rd_valid); end
        checks++; if (bus.level !== 5'd1 || bus.empty !== 1'b0) begin
            failures++; $display("FAIL empty_rw_level got=%0d/%b exp=1/0", bus.level, bus.empty);
        end
        drive(1'b0, 12'h000, 1'b1, 1'b0);
        checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 12'h123) begin
            failures++; $display("FAIL empty_rw_data got=%b/%h exp=1/123", bus.rd_valid, bus.rd_data);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 12'(i * 37 + 5), 1'b0, 1'b0);
            drive(1'b0, 12'h000, 1'b1, 1'b0);
            checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 12'(i * 37 + 5)) begin
                failures++; $display("FAIL wrap_data i=%0d got=%b/%h exp=1/%h", i, bus.rd_valid, bus.rd_data, 12'(i * 37 + 5));
            end
        end
        checks++; if (bus.level !== 5'd0) begin failures++; $display("FAIL wrap_level got=%0d exp=0", bus.level); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 16; i++) drive(1'b1, 12'(i), 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) drive(1'b1, 12'hEEE, 1'b0, 1'b0);
        checks++; if (bus.overrun !== 1'b1 || bus.overrun_cnt !== 8'd255) begin
            failures++; $display("FAIL sat_count got=%b/%0d exp=1/255", bus.overrun, bus.overrun_cnt);
        end
        drive(1'b1, 12'hEEE, 1'b0, 1'b1);
        checks++; if (bus.overrun !== 1'b1 || bus.overrun_cnt !== 8'd1) begin
            failures++; $display("FAIL clr_with_drop got=%b/%0d exp=1/1", bus.overrun, bus.overrun_cnt);
        end
        drive(1'b0, 12'h000, 1'b0, 1'b1);
        checks++; if (bus.overrun !== 1'b0 || bus.overrun_cnt !== 8'd0) begin
            failures++; $display("FAIL clr_alone got=%b/%0d exp=0/0", bus.overrun, bus.overrun_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, 12'(i + 8'h50), 1'b0, 1'b0);
        drive(1'b1, 12'hDDD, 1'b0, 1'b0);
        drive(1'b0, 12'h000, 1'b1, 1'b0);
        checks++; if (bus.level !== 5'd5 || bus.rd_valid !== 1'b1) begin
            failures++; $display("FAIL mid_level got=%0d/%b exp=5/1", bus.level, bus.rd_valid);
        end
        rst = 1'b1;
        drive(1'b1, 12'h321, 1'b1, 1'b0);
        rst = 1'b0;
        checks++; if (bus.level !== 5'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.wmark !== 1'b0) begin
            failures++; $display("FAIL mid_status got=%0d/%b/%b/%b exp=0/1/0/0", bus.level, bus.empty, bus.full, bus.wmark);
        end
        checks++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 12'h000 || bus.overrun_cnt !== 8'd0) begin
            failures++; $display("FAIL mid_outputs got=%b/%h/%0d exp=0/000/0", bus.rd_valid, bus.rd_data, bus.overrun_cnt);
        end
        drive(1'b0, 12'h000, 1'b1, 1'b0);
        checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL mid_discard got=%b exp=0", bus.rd_valid); end
    endtask

    initial begin
        bus.new_data    = 1'b0;
        bus.data_in     = '0;
        bus.rd_en       = 1'b0;
        bus.clr_overrun = 1'b0;
        test_reset();
        test_fill_drain();
        test_overrun();
        test_simul_full();
        test_empty_rw();
        test_wrap();
        test_saturate();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sample_fifo.md
Name: sample_fifo

Overview:
- Output buffer directly downstream of the CIC decimator.
- Captures each 12-bit decimated sample on its one-cycle new_data strobe and holds it in a circular FIFO.
- A host-side reader (register interface or a future DMA/SPI burst engine) drains the FIFO at its own pace.
- Provides full/empty/level status, a watermark flag, and sticky overrun accounting for samples dropped while full.

Parameters:
- DATA_W, 12, sample width; matches the decimator output width.
- DEPTH, 16, number of entries; must be a power of 2, ≥ 4.
- AW, 4, address width; must equal log2(DEPTH).
- WMARK, 8, level threshold for wmark; range 1..DEPTH.

Ports:
- clk  input  1  system clock, same clock as the decimator.
- rst  input  1  synchronous, active-high reset.
- data_in  input  DATA_W  decimated sample.
- new_data  input  1  one-cycle write strobe accompanying data_in.
- rd_en  input  1  read request.
- clr_overrun  input  1  one-cycle clear of overrun and overrun_cnt.
- rd_data  output  DATA_W  read sample, registered.
- rd_valid  output  1  one-cycle pulse marking rd_data valid.
- empty  output  1  FIFO holds 0 entries.
- full  output  1  FIFO holds DEPTH entries.
- level  output  AW+1  current entry count, 0..DEPTH.
- wmark  output  1  high while level ≥ WMARK.
- overrun  output  1  sticky flag: a sample was dropped.
- overrun_cnt  output  8  dropped-sample count, saturating at 255.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst; all state changes on posedge clk.
- Reset values: wr_ptr = 0, rd_ptr = 0, level = 0, empty = 1, full = 0, wmark = 0, rd_data = 0, rd_valid = 0, overrun = 0, overrun_cnt = 0.
- Reset takes priority over all other inputs. Reset mid-operation discards stored data; memory contents need not be cleared.
- Storage: DEPTH × DATA_W register array. Pointers are AW bits and wrap naturally from DEPTH-1 to 0.
- Write acceptance: accepted when new_data = 1 and (full = 0 or a read is accepted in the same cycle). An accepted write stores data_in at wr_ptr and increments wr_ptr.
- Read acceptance: accepted when rd_en = 1 and empty = 0.
  - An accepted read loads mem[rd_ptr] into rd_data and increments rd_ptr.
  - rd_valid = 1 in the following cycle only; read latency is 1 cycle.
  - rd_data holds its value until the next accepted read.
- Read while empty: ignored. rd_valid stays 0, nothing changes. There is no fall-through: a write and read in the same cycle while empty accepts the write only.
- Simultaneous accepted read and write: level unchanged, both pointers advance. At full, this frees a slot, so the write is not dropped.
- Level, empty, full and wmark are registered and updated in the same edge as the pointer changes:
  - level: +1 on write only, −1 on read only, unchanged otherwise.
  - empty = (level == 0).
  - full = (level == DEPTH).
  - wmark = (level ≥ WMARK).
- Overrun: new_data = 1 while full = 1 with no accepted read drops the sample.
  - The dropped sample leaves memory and pointers unchanged.
  - overrun is set to 1.
  - overrun_cnt increments, saturating at 255.
- clr_overrun: clears overrun and overrun_cnt to 0.
  - If a drop occurs in the same cycle, the drop wins: overrun = 1, overrun_cnt = 1.
- new_data is expected at most once per decimation period. Back-to-back strobes must still be handled correctly every cycle.

Test Plan:
- Reset then idle: assert rst for 2 cycles → empty = 1, level = 0, full = 0, wmark = 0, rd_valid = 0, overrun_cnt = 0.
- Write 0x001..0x010 (16 strobes), then read 16 times → full = 1 after the 16th write; wmark rises when level reaches 8; rd_data sequence is 0x001..0x010, each with a 1-cycle rd_valid one cycle after its rd_en; empty = 1 at the end.
- Fill to 16, then write 3 more strobes (0xAAA, 0xBBB, 0xCCC) → level stays 16; overrun = 1, overrun_cnt = 3; reads return 0x001..0x010 with no 0xAAA.
- At full, new_data = 1 with data 0x7FF and rd_en = 1 in the same cycle → rd_data = 0x001, level stays 16, overrun unchanged; 0x7FF is read last.
- Empty FIFO, rd_en = 1 and new_data = 1 (0x123) in the same cycle → no rd_valid, level = 1; next read returns 0x123.
- Pointer wrap: 40 interleaved write/read pairs → data is returned in order across the wrap. Separately, cause 300 drops → overrun_cnt = 255. clr_overrun coinciding with a drop → overrun_cnt = 1. Assert rst while level = 5 → all outputs return to reset values next cycle.
